platform_field: RTL and testbench

Per-frame platform manager for the jumper game and the responder to the ball's landing query. It holds the on-screen platform set, answers "is the ball landing on a platform this frame", scrolls the field down when the ball climbs past the scroll line, recycles platforms that fall off the bottom with pseudo-random X positions, and keeps the height score. It sits between the ball motion block, which supplies position and velocity and consumes `land`, and the VGA colour mapper, which reads platform coordinates by index.

---
 rtl/platform_pkg.sv | 27 ++
 rtl/plat_lfsr.sv | 37 +++
 rtl/platform_field.sv | 221 ++++++++++++++++++++++
 tb/tb_platform_field.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// Shared definitions for the jumper-game platform field: the FSM state
// encoding, the start-of-game platform layout, the ball geometry and the
// constants of the X-position LFSR.
package platform_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Start-of-game layout, element i is slot i.
    localparam logic [7:0][10:0] INIT_X = {
        11'd330, 11'd130, 11'd180, 11'd290, 11'd250, 11'd317, 11'd165, 11'd240
    };
    localparam logic [7:0][10:0] INIT_Y = {
        11'd377, 11'd352, 11'd385, 11'd422, 11'd400, 11'd450, 11'd455, 11'd470
    };

    localparam int BALL_W  = 8;
    localparam int BALL_H  = 10;
    localparam int BALL_CX = BALL_W / 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/plat_lfsr.sv
// 16-bit Galois LFSR used to pick X positions for recycled platforms.
// The low nine state bits are folded into [0, X_MAX] by subtracting 256
// when they land past the right-hand limit.
module plat_lfsr
    import platform_pkg::*;
#(
    parameter int X_MAX = 568
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [10:0] x_o
);

    logic [15:0] lfsr_q, lfsr_d;
    logic [10:0] raw_x;

    // Galois shift when enabled, and the folded X position from the current state.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
        raw_x = {2'b00, lfsr_q[8:0]};
        x_o   = (raw_x > 11'(X_MAX)) ? (raw_x - 11'd256) : raw_x;
    end

    // State register, reseeded on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/platform_field.sv
// Per-frame platform manager: landing detection, field scrolling, platform
// recycling with LFSR X positions, height score and game-over detection.
// One clock per video frame. Optional macro PLATFORM_FIELD_MOVING_EN makes
// odd-index platforms patrol horizontally by 1 px per frame.
module platform_field
    import platform_pkg::*;
#(
    parameter int NUM_PLAT    = 8,
    parameter int PLAT_W      = 72,
    parameter int LAND_TOL    = 5,
    parameter int SCROLL_LINE = 200,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [10:0]        BallX,
    input  logic [10:0]        BallY,
    input  logic signed [9:0]  BallVY,
    input  logic               start,
    output logic               land,
    output logic [10:0]        land_y,
    output logic [9:0]         scroll_dy,
    output logic [15:0]        score,
    output logic               game_over,
    input  logic [2:0]         rd_idx,
    output logic [10:0]        rd_x,
    output logic [10:0]        rd_y
);

    localparam int          IDX_W = $clog2(NUM_PLAT);
    localparam logic [10:0] X_LIM = 11'(SCREEN_W - PLAT_W);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
    logic [10:0]        px_q [NUM_PLAT];
    logic [10:0]        px_d [NUM_PLAT];
    logic [10:0]        py_q [NUM_PLAT];
    logic [10:0]        py_d [NUM_PLAT];
    logic               land_q, land_d;
    logic [10:0]        land_y_q, land_y_d;
    logic [9:0]         scroll_q, scroll_d;
    logic [15:0]        score_q, score_d;
    logic               go_q, go_d;

    logic [10:0]        cx, foot, vy_mag, lfsr_x;
    logic [9:0]         dy;
    logic [16:0]        score_sum;
    logic               hit, rec, scroll_en;
    logic [IDX_W-1:0]   hit_idx, rec_idx;

`ifdef PLATFORM_FIELD_MOVING_EN
    logic [NUM_PLAT/2-1:0] dir_q, dir_d;
    logic [10:0]           nx;
`endif

    // Landing window test, widened to 12 bits so the tolerance band never wraps.
    function automatic logic slot_hit(input logic [10:0] px, input logic [10:0] py,
                                      input logic [10:0] cxv, input logic [10:0] footv);
        logic [11:0] px12, py12, cx12, ft12;
        px12 = {1'b0, px};
        py12 = {1'b0, py};
        cx12 = {1'b0, cxv};
        ft12 = {1'b0, footv};
        return (cx12 >= px12) && (cx12 <= px12 + 12'(PLAT_W - 1)) &&
               (ft12 + 12'(LAND_TOL) >= py12) && (ft12 < py12 + 12'(LAND_TOL));
    endfunction

    plat_lfsr #(
        .X_MAX (SCREEN_W - PLAT_W)
    ) u_lfsr (
        .clk_i (frame_clk),
        .rst_i (Reset),
        .en_i  (state_q != ST_OVER),
        .x_o   (lfsr_x)
    );

    // Frame evaluation: ball geometry, landing search, recycle search and next state.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        px_d       = px_q;
        py_d       = py_q;
        land_d     = 1'b0;
        land_y_d   = land_y_q;
        scroll_d   = 10'd0;
        score_d    = score_q;
        go_d       = go_q;
`ifdef PLATFORM_FIELD_MOVING_EN
        dir_d      = dir_q;
        nx         = 11'd0;
`endif

        cx        = BallX + 11'(BALL_CX);
        foot      = BallY + 11'(BALL_H);
        vy_mag    = -{BallVY[9], BallVY};
        dy        = (vy_mag > 11'd511) ? 10'd511 : vy_mag[9:0];
        scroll_en = (BallY < 11'(SCROLL_LINE)) && BallVY[9];
        score_sum = {1'b0, score_q} + 17'(dy);

        // Reverse scans leave the lowest matching index in the result.
        hit     = 1'b0;
        hit_idx = '0;
        rec     = 1'b0;
        rec_idx = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if ((BallVY > 10'sd0) && slot_hit(px_q[i], py_q[i], cx, foot)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (py_q[i] >= 11'(SCREEN_H)) begin
                rec     = 1'b1;
                rec_idx = IDX_W'(i);
            end
        end

        case (state_q)
            ST_INIT: begin
                go_d             = 1'b0;
                px_d[init_cnt_q] = INIT_X[init_cnt_q];
                py_d[init_cnt_q] = INIT_Y[init_cnt_q];
                if (init_cnt_q == IDX_W'(NUM_PLAT - 1)) begin
                    init_cnt_d = '0;
                    state_d    = ST_PLAY;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end

            ST_PLAY: begin
                if (foot >= 11'(SCREEN_H - 1)) begin
                    state_d = ST_OVER;
                    go_d    = 1'b1;
                end else begin
                    land_d = hit;
                    if (hit) begin
                        land_y_d = py_q[hit_idx] - 11'(BALL_H);
                    end
                    if (scroll_en) begin
                        scroll_d = dy;
                        score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        for (int i = 0; i < NUM_PLAT; i++) begin
                            py_d[i] = py_q[i] + {1'b0, dy};
                        end
                    end
`ifdef PLATFORM_FIELD_MOVING_EN
                    for (int i = 1; i < NUM_PLAT; i += 2) begin
                        if (dir_q[i/2]) begin
                            nx = (px_q[i] == 11'd0) ? (px_q[i] + 11'd1) : (px_q[i] - 11'd1);
                        end else begin
                            nx = (px_q[i] >= X_LIM) ? (px_q[i] - 11'd1) : (px_q[i] + 11'd1);
                        end
                        px_d[i]     = nx;
                        dir_d[i/2]  = (nx == 11'd0) ? 1'b0 : ((nx >= X_LIM) ? 1'b1 : dir_q[i/2]);
                    end
`endif
                    // The recycled slot overrides any scroll or move applied above.
                    if (rec) begin
                        py_d[rec_idx] = 11'd0;
                        px_d[rec_idx] = lfsr_x;
                    end
                end
            end

            ST_OVER: begin
                if (start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    score_d    = 16'd0;
                    go_d       = 1'b0;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Frame registers; reset clears the whole field at once.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                px_q[i] <= 11'd0;
                py_q[i] <= 11'd0;
            end
            land_q     <= 1'b0;
            land_y_q   <= 11'd0;
            scroll_q   <= 10'd0;
            score_q    <= 16'd0;
            go_q       <= 1'b0;
`ifdef PLATFORM_FIELD_MOVING_EN
            dir_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            px_q       <= px_d;
            py_q       <= py_d;
            land_q     <= land_d;
            land_y_q   <= land_y_d;
            scroll_q   <= scroll_d;
            score_q    <= score_d;
            go_q       <= go_d;
`ifdef PLATFORM_FIELD_MOVING_EN
            dir_q      <= dir_d;
`endif
        end
    end

    assign land      = land_q;
    assign land_y    = land_y_q;
    assign scroll_dy = scroll_q;
    assign score     = score_q;
    assign game_over = go_q;
    assign rd_x      = px_q[rd_idx];
    assign rd_y      = py_q[rd_idx];

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field: reset state, INIT loading, a table of
// landing/scroll vectors, platform recycling, game over, restart and reset
// during INIT.
`timescale 1ns/1ps
module tb_platform_field;

    logic              frame_clk = 1'b0;
    logic              Reset;
    logic [10:0]       BallX, BallY;
    logic signed [9:0] BallVY;
    logic              start;
    logic              land;
    logic [10:0]       land_y;
    logic [9:0]        scroll_dy;
    logic [15:0]       score;
    logic              game_over;
    logic [2:0]        rd_idx;
    logic [10:0]       rd_x, rd_y;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    logic [15:0] lfsr_used;
    logic        run_m;
    logic [10:0] rec_x;

    typedef struct {
        logic [10:0]       bx;
        logic [10:0]       by;
        logic signed [9:0] vy;
        logic              e_land;
        logic [10:0]       e_land_y;
        logic [9:0]        e_sdy;
        logic [15:0]       e_score;
    } vec_t;

    vec_t vt [14];

    logic [7:0][10:0] IX, IY;

    always #10 frame_clk = ~frame_clk;

    platform_field dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallVY    (BallVY),
        .start     (start),
        .land      (land),
        .land_y    (land_y),
        .scroll_dy (scroll_dy),
        .score     (score),
        .game_over (game_over),
        .rd_idx    (rd_idx),
        .rd_x      (rd_x),
        .rd_y      (rd_y)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [10:0] lfsr_xf(input logic [15:0] v);
        logic [10:0] x;
        x = {2'b00, v[8:0]};
        if (x > 11'd568) x = x - 11'd256;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_slot(input int idx, input logic [10:0] ex, input logic [10:0] ey);
        rd_idx = 3'(idx);
        #1;
        chk($sformatf("slot%0d_x", idx), {21'd0, rd_x}, {21'd0, ex});
        chk($sformatf("slot%0d_y", idx), {21'd0, rd_y}, {21'd0, ey});
    endtask

    task automatic chk_outs(input string nm, input logic e_land, input logic [9:0] e_sdy,
                            input logic [15:0] e_score, input logic e_go);
        chk({nm, "_land"},   {31'd0, land},      {31'd0, e_land});
        chk({nm, "_scroll"}, {22'd0, scroll_dy}, {22'd0, e_sdy});
        chk({nm, "_score"},  {16'd0, score},     {16'd0, e_score});
        chk({nm, "_over"},   {31'd0, game_over}, {31'd0, e_go});
    endtask

    // One frame: the LFSR value the DUT uses at this edge is saved first.
    task automatic step;
        lfsr_used = lfsr_m;
        @(posedge frame_clk);
        #1;
        if (run_m) lfsr_m = lfsr_next(lfsr_m);
    endtask

    initial begin
        IX = {11'd330, 11'd130, 11'd180, 11'd290, 11'd250, 11'd317, 11'd165, 11'd240};
        IY = {11'd377, 11'd352, 11'd385, 11'd422, 11'd400, 11'd450, 11'd455, 11'd470};

        //          bx        by        vy       land  land_y   sdy     score
        vt[0]  = '{11'd276, 11'd458,  10'sd2,  1'b1, 11'd460, 10'd0, 16'd0};
        vt[1]  = '{11'd276, 11'd458, -10'sd3,  1'b0, 11'd0,   10'd0, 16'd0};
        vt[2]  = '{11'd236, 11'd455,  10'sd1,  1'b1, 11'd460, 10'd0, 16'd0};
        vt[3]  = '{11'd307, 11'd464,  10'sd1,  1'b1, 11'd460, 10'd0, 16'd0};
        vt[4]  = '{11'd308, 11'd464,  10'sd1,  1'b0, 11'd0,   10'd0, 16'd0};
        vt[5]  = '{11'd276, 11'd465,  10'sd1,  1'b0, 11'd0,   10'd0, 16'd0};
        vt[6]  = '{11'd276, 11'd458,  10'sd0,  1'b0, 11'd0,   10'd0, 16'd0};
        vt[7]  = '{11'd260, 11'd392,  10'sd1,  1'b1, 11'd390, 10'd0, 16'd0};
        vt[8]  = '{11'd276, 11'd468,  10'sd0,  1'b0, 11'd0,   10'd0, 16'd0};
        vt[9]  = '{11'd0,   11'd200, -10'sd3,  1'b0, 11'd0,   10'd0, 16'd0};
        vt[10] = '{11'd0,   11'd199, -10'sd3,  1'b0, 11'd0,   10'd3, 16'd3};
        vt[11] = '{11'd0,   11'd199, -10'sd3,  1'b0, 11'd0,   10'd3, 16'd6};
        vt[12] = '{11'd0,   11'd199, -10'sd3,  1'b0, 11'd0,   10'd3, 16'd9};
        vt[13] = '{11'd0,   11'd199, -10'sd3,  1'b0, 11'd0,   10'd3, 16'd12};

        Reset  = 1'b1;
        start  = 1'b0;
        BallX  = 11'd0;
        BallY  = 11'd300;
        BallVY = 10'sd0;
        rd_idx = 3'd0;
        run_m  = 1'b1;
        lfsr_m = 16'hACE1;
        lfsr_used = 16'hACE1;
        rec_x  = 11'd0;

        // Reset state.
        #3;
        chk_outs("rst", 1'b0, 10'd0, 16'd0, 1'b0);
        chk("rst_land_y", {21'd0, land_y}, 32'd0);
        chk_slot(0, 11'd0, 11'd0);
        @(negedge frame_clk);
        Reset = 1'b0;

        // INIT loads one slot per frame.
        for (int k = 0; k < 3; k++) step();
        chk_slot(2, 11'd317, 11'd450);
        chk_slot(3, 11'd0, 11'd0);
        for (int k = 0; k < 5; k++) step();
        for (int i = 0; i < 8; i++) chk_slot(i, IX[i], IY[i]);

        // Landing and scroll vectors in PLAY.
        for (int i = 0; i < 14; i++) begin
            BallX  = vt[i].bx;
            BallY  = vt[i].by;
            BallVY = vt[i].vy;
            step();
            chk_outs($sformatf("vec%0d", i), vt[i].e_land, vt[i].e_sdy, vt[i].e_score, 1'b0);
            if (vt[i].e_land) chk($sformatf("vec%0d_land_y", i), {21'd0, land_y}, {21'd0, vt[i].e_land_y});
        end
        for (int i = 0; i < 8; i++) chk_slot(i, IX[i], IY[i] + 11'd12);

        // Slot 0 sits at 482: it respawns and does not scroll; the others do.
        BallX = 11'd0; BallY = 11'd150; BallVY = -10'sd3;
        step();
        rec_x = lfsr_xf(lfsr_used);
        chk_outs("rec1", 1'b0, 10'd3, 16'd15, 1'b0);
        chk_slot(0, rec_x, 11'd0);
        for (int i = 1; i < 8; i++) chk_slot(i, IX[i], IY[i] + 11'd15);

        // Foot exactly at SCREEN_H-1 ends the game.
        BallX = 11'd276; BallY = 11'd469; BallVY = 10'sd0;
        step();
        chk_outs("over", 1'b0, 10'd0, 16'd15, 1'b1);

        // OVER freezes everything, including the LFSR.
        run_m = 1'b0;
        BallX = 11'd180; BallY = 11'd460; BallVY = 10'sd2;
        step();
        chk_outs("frz_land", 1'b0, 10'd0, 16'd15, 1'b1);
        BallX = 11'd0; BallY = 11'd150; BallVY = -10'sd3;
        step();
        chk_outs("frz_scroll", 1'b0, 10'd0, 16'd15, 1'b1);
        chk_slot(0, rec_x, 11'd0);
        chk_slot(1, 11'd165, 11'd470);

        // start returns to INIT and clears the score.
        start = 1'b1;
        step();
        chk_outs("restart", 1'b0, 10'd0, 16'd0, 1'b0);
        start = 1'b0;
        run_m = 1'b1;
        BallY = 11'd300; BallVY = 10'sd0;
        for (int k = 0; k < 8; k++) step();
        for (int i = 0; i < 8; i++) chk_slot(i, IX[i], IY[i]);

        BallY = 11'd150; BallVY = -10'sd3;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_outs($sformatf("scr%0d", k), 1'b0, 10'd3, 16'(3 * k), 1'b0);
        end
        BallY = 11'd300; BallVY = 10'sd0;
        step();
        chk_outs("rec2", 1'b0, 10'd0, 16'd12, 1'b0);
        chk_slot(0, lfsr_xf(lfsr_used), 11'd0);
        chk_slot(1, 11'd165, 11'd467);

        // Asynchronous reset during PLAY.
        #2;
        Reset = 1'b1;
        #1;
        chk_outs("arst", 1'b0, 10'd0, 16'd0, 1'b0);
        chk_slot(0, 11'd0, 11'd0);
        chk_slot(7, 11'd0, 11'd0);
        @(negedge frame_clk);
        Reset = 1'b0;

        // Reset in the middle of INIT restarts loading from slot 0.
        for (int k = 0; k < 3; k++) step();
        chk_slot(2, 11'd317, 11'd450);
        #2;
        Reset = 1'b1;
        #1;
        chk_slot(0, 11'd0, 11'd0);
        chk_slot(2, 11'd0, 11'd0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step();
        chk_slot(0, 11'd240, 11'd470);
        chk_slot(1, 11'd0, 11'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
